pipelined_addr_adder: RTL and testbench

Parametrised, pipelined successor to the combinational 64-bit ripple address adder used for PC/branch-target and load/store address generation. It splits the carry chain into STAGES registered chunks to shorten the critical path. It adds subtract mode, optional left-scaling of B for word-offset branches, and status flags. A valid/ready handshake supports back-pressure from the consuming pipeline stage.

---
 rtl/pipelined_addr_adder.sv | 125 ++++++++++++
 tb/tb_pipelined_addr_adder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addr_adder.sv
// pipelined_addr_adder: address adder whose carry chain is cut into STAGES
// registered chunks. Supports subtract, optional left-scaling of B, status
// flags and a valid/ready handshake where every stage advances together.
module pipelined_addr_adder #(
   parameter int WIDTH  = 64,
   parameter int STAGES = 4,   // WIDTH must be a multiple of STAGES
   parameter int SHIFT  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             sub,
   input  logic             scale,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int CW   = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   logic              adv;
   logic [STAGES-1:0] vld_pipe;
   logic [WIDTH-1:0]  b_scl;
   logic [WIDTH-1:0]  bx;
   logic              cin;

   // The whole pipe moves as one: it only stalls when a result is waiting
   // and the consumer refuses it.
   assign out_valid = vld_pipe[LAST];
   assign adv       = ~out_valid | out_ready;
   assign in_ready  = adv;

   // Operand prep: scale B, then invert and inject carry-in for subtract.
   always_comb begin
      b_scl = scale ? (B << SHIFT) : B;
      bx    = sub ? ~b_scl : b_scl;
      cin   = sub;
   end

   // Valid bits shift with the data; bubbles travel like real operations.
   always_ff @(posedge clk) begin
      if (reset)
         vld_pipe <= '0;
      else if (adv)
         vld_pipe <= STAGES'({vld_pipe, in_valid});
   end

   for (genvar k = 0; k < STAGES; k++) begin : stg
      logic [WIDTH-1:0] a_in, bx_in, s_in, s_nxt;
      logic             c_in;
      logic [CW-1:0]    a_ch, b_ch;
      logic [CW:0]      chunk;

      if (k == 0) begin : src
         assign a_in  = A;
         assign bx_in = bx;
         assign s_in  = '0;
         assign c_in  = cin;
      end else begin : src
         assign a_in  = stg[k-1].pass.a_q;
         assign bx_in = stg[k-1].pass.bx_q;
         assign s_in  = stg[k-1].pass.s_q;
         assign c_in  = stg[k-1].pass.c_q;
      end

      assign a_ch  = CW'(a_in >> (k*CW));
      assign b_ch  = CW'(bx_in >> (k*CW));
      assign chunk = {1'b0, a_ch} + {1'b0, b_ch} + {{CW{1'b0}}, c_in};

      // Merge this stage's chunk into the partial sum carried so far.
      always_comb begin
         s_nxt               = s_in;
         s_nxt[k*CW +: CW]   = chunk[CW-1:0];
      end

      // Intermediate stages carry operands, partial sum and chunk carry on;
      // the last stage feeds the output registers instead.
      if (k < LAST) begin : pass
         logic [WIDTH-1:0] a_q, bx_q, s_q;
         logic             c_q;

         // Stage register; contents are don't-care while its valid bit is 0.
         always_ff @(posedge clk) begin
            if (adv) begin
               a_q  <= a_in;
               bx_q <= bx_in;
               s_q  <= s_nxt;
               c_q  <= chunk[CW];
            end
         end
      end
   end

   logic [WIDTH-1:0] s_fin;
   logic             c_fin;
   logic             c_msb;

   // Carry into the MSB recovered from the MSB's own sum and operand bits.
   assign s_fin = stg[LAST].s_nxt;
   assign c_fin = stg[LAST].chunk[CW];
   assign c_msb = stg[LAST].a_ch[CW-1] ^ stg[LAST].b_ch[CW-1] ^ s_fin[WIDTH-1];

   // Result and flags are registered together with the final chunk.
   always_ff @(posedge clk) begin
      if (reset) begin
         sum       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
      end else if (adv) begin
         sum       <= s_fin;
         carry_out <= c_fin;
         overflow  <= c_msb ^ c_fin;
         zero      <= (s_fin == '0);
      end
   end

endmodule

// File: tb/tb_pipelined_addr_adder.sv
// Bench for pipelined_addr_adder: three instances (STAGES 1, 4, 8) share the
// operand buses; each has its own in_valid so streams can target one depth.
module tb_pipelined_addr_adder;
   localparam int W = 64;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         o;
      logic         z;
   } res_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sb;
      logic         sc;
      res_t         e;
   } vec_t;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [2:0]         in_vld, in_rdy, out_vld;
   logic               out_ready;
   logic [W-1:0]       A, B;
   logic               sub, scale;
   logic [2:0][W-1:0]  sum_o;
   logic [2:0]         c_o, o_o, z_o;
   int                 STG [3] = '{1, 4, 8};

   int   checks = 0;
   int   errors = 0;
   int   del_cnt [3] = '{0, 0, 0};
   res_t q [3][$];

   always #5 clk = ~clk;

   pipelined_addr_adder #(.WIDTH(W), .STAGES(1), .SHIFT(2)) u_s1 (
      .clk(clk), .reset(reset), .in_valid(in_vld[0]), .in_ready(in_rdy[0]),
      .A(A), .B(B), .sub(sub), .scale(scale), .out_valid(out_vld[0]),
      .out_ready(out_ready), .sum(sum_o[0]), .carry_out(c_o[0]),
      .overflow(o_o[0]), .zero(z_o[0]));

   pipelined_addr_adder #(.WIDTH(W), .STAGES(4), .SHIFT(2)) u_s4 (
      .clk(clk), .reset(reset), .in_valid(in_vld[1]), .in_ready(in_rdy[1]),
      .A(A), .B(B), .sub(sub), .scale(scale), .out_valid(out_vld[1]),
      .out_ready(out_ready), .sum(sum_o[1]), .carry_out(c_o[1]),
      .overflow(o_o[1]), .zero(z_o[1]));

   pipelined_addr_adder #(.WIDTH(W), .STAGES(8), .SHIFT(2)) u_s8 (
      .clk(clk), .reset(reset), .in_valid(in_vld[2]), .in_ready(in_rdy[2]),
      .A(A), .B(B), .sub(sub), .scale(scale), .out_valid(out_vld[2]),
      .out_ready(out_ready), .sum(sum_o[2]), .carry_out(c_o[2]),
      .overflow(o_o[2]), .zero(z_o[2]));

   // Reference: plain wide arithmetic and signed-overflow sign rules.
   function automatic res_t model(input logic [W-1:0] a, b, input logic sb, sc);
      logic [W-1:0] bp;
      logic [W:0]   full;
      res_t         r;
      bp = sc ? (b << 2) : b;
      if (sb) begin
         full = {1'b0, a} - {1'b0, bp};
         r.c  = (a >= bp);
         r.s  = full[W-1:0];
         r.o  = (a[W-1] != bp[W-1]) && (r.s[W-1] != a[W-1]);
      end else begin
         full = {1'b0, a} + {1'b0, bp};
         r.c  = full[W];
         r.s  = full[W-1:0];
         r.o  = (a[W-1] == bp[W-1]) && (r.s[W-1] != a[W-1]);
      end
      r.z = (r.s == '0);
      return r;
   endfunction

   function automatic res_t cur(input int i);
      res_t r;
      r.s = sum_o[i];
      r.c = c_o[i];
      r.o = o_o[i];
      r.z = z_o[i];
      return r;
   endfunction

   task automatic chk_bit(input string nm, input int i, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s s%0d: got %b expected %b", nm, STG[i], act, exp);
      end
   endtask

   task automatic chk_res(input string nm, input int i, input res_t act, input res_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s s%0d: got sum=%h c=%b o=%b z=%b expected sum=%h c=%b o=%b z=%b",
                  nm, STG[i], act.s, act.c, act.o, act.z, exp.s, exp.c, exp.o, exp.z);
      end
   endtask

   task automatic chk_int(input string nm, input int i, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s s%0d: got %0d expected %0d", nm, STG[i], act, exp);
      end
   endtask

   // Scoreboard: pop on delivery before pushing this edge's accept.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            q[i].delete();
         end else begin
            if (out_vld[i] && out_ready) begin
               if (q[i].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL spurious_out s%0d: out_valid with nothing in flight", STG[i]);
               end else begin
                  automatic res_t e = q[i].pop_front();
                  chk_res("sb_result", i, cur(i), e);
                  del_cnt[i]++;
               end
            end
            if (in_vld[i] && in_rdy[i])
               q[i].push_back(model(A, B, sub, scale));
         end
      end
   end

   // One op into all three instances; check exact latency and table result.
   task automatic run_vec(input vec_t v);
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_vld = 3'b111;
      A = v.a; B = v.b; sub = v.sb; scale = v.sc;
      @(posedge clk); #1;
      in_vld = 3'b000;
      for (int e = 1; e <= 8; e++) begin
         if (e > 1) begin
            @(posedge clk); #1;
         end
         for (int i = 0; i < 3; i++) begin
            if (e < STG[i]) begin
               chk_bit("early_valid", i, out_vld[i], 1'b0);
            end else if (e == STG[i]) begin
               chk_bit("latency_valid", i, out_vld[i], 1'b1);
               chk_res("vec_result", i, cur(i), v.e);
            end
         end
      end
   endtask

   // Back-to-back random stream into one instance with a 3-cycle stall.
   task automatic stream(input int idx, input int n);
      logic [W-1:0] oa [12];
      logic [W-1:0] ob [12];
      logic         os [12];
      logic         oc [12];
      logic [W-1:0] held;
      logic         prev_st;
      int k, cyc, d0, stall_at;
      for (int j = 0; j < n; j++) begin
         oa[j] = {$urandom(), $urandom()};
         ob[j] = (j % 4 == 3) ? oa[j] : {$urandom(), $urandom()};
         os[j] = (j % 4 == 3) ? 1'b1 : 1'($urandom_range(0, 1));
         oc[j] = (j % 4 == 3) ? 1'b0 : 1'($urandom_range(0, 1));
      end
      k = 0; cyc = 0; d0 = del_cnt[idx]; stall_at = STG[idx];
      prev_st = 1'b0; held = '0;
      while ((k < n || del_cnt[idx] - d0 < n) && cyc < 200) begin
         @(posedge clk); #1;
         out_ready = !(cyc >= stall_at && cyc < stall_at + 3);
         if (k < n) begin
            in_vld[idx] = 1'b1;
            A = oa[k]; B = ob[k]; sub = os[k]; scale = oc[k];
         end else begin
            in_vld[idx] = 1'b0;
         end
         @(negedge clk);
         if (!out_ready && out_vld[idx]) begin
            chk_bit("stall_in_ready", idx, in_rdy[idx], 1'b0);
            if (prev_st) chk_res("stall_hold", idx, cur(idx), {held, c_o[idx], o_o[idx], z_o[idx]});
            held = sum_o[idx];
            prev_st = 1'b1;
         end else begin
            prev_st = 1'b0;
         end
         if (in_vld[idx] && in_rdy[idx]) k++;
         cyc++;
      end
      @(posedge clk); #1;
      in_vld[idx] = 1'b0;
      out_ready = 1'b1;
      chk_int("stream_delivered", idx, del_cnt[idx] - d0, n);
   endtask

   vec_t vt [11];

   initial begin
      vt[0]  = '{64'd54213, 64'd42135, 1'b0, 1'b0, '{64'd96348, 1'b0, 1'b0, 1'b0}};
      vt[1]  = '{64'd5, 64'd7, 1'b1, 1'b0, '{64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0}};
      vt[2]  = '{64'h1234, 64'h1234, 1'b1, 1'b0, '{64'h0, 1'b1, 1'b0, 1'b1}};
      vt[3]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, '{64'h0, 1'b1, 1'b0, 1'b1}};
      vt[4]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, '{64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0}};
      vt[5]  = '{64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, '{64'hFFC, 1'b1, 1'b0, 1'b0}};
      vt[6]  = '{64'h400, 64'h10, 1'b0, 1'b1, '{64'h440, 1'b0, 1'b0, 1'b0}};
      vt[7]  = '{64'h100, 64'h40, 1'b1, 1'b1, '{64'h0, 1'b1, 1'b0, 1'b1}};
      vt[8]  = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, '{64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0}};
      vt[9]  = '{64'h0, 64'hC000_0000_0000_0001, 1'b0, 1'b1, '{64'h4, 1'b0, 1'b0, 1'b0}};
      vt[10] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, '{64'h1_0000_0000, 1'b0, 1'b0, 1'b0}};

      in_vld = 3'b000; out_ready = 1'b1;
      A = '0; B = '0; sub = 1'b0; scale = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk_bit("reset_out_valid", i, out_vld[i], 1'b0);
         chk_res("reset_outputs", i, cur(i), '0);
      end
      reset = 1'b0;

      // Directed vectors with exact latency.
      for (int v = 0; v < 11; v++) run_vec(vt[v]);

      // Random streams with back-pressure, one depth at a time.
      for (int i = 0; i < 3; i++) stream(i, 12);

      // Fill with three ops, then reset (with an op presented in that cycle).
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int j = 0; j < 3; j++) begin
         in_vld = 3'b111;
         A = {$urandom(), $urandom()}; B = {$urandom(), $urandom()};
         sub = 1'($urandom_range(0, 1)); scale = 1'b0;
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      in_vld = 3'b000;
      for (int i = 0; i < 3; i++) begin
         chk_bit("post_reset_valid", i, out_vld[i], 1'b0);
         chk_res("post_reset_outputs", i, cur(i), '0);
      end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 3; i++) chk_bit("no_stale", i, out_vld[i], 1'b0);
      end

      // Fresh op after reset keeps the exact latency.
      run_vec(vt[0]);
      run_vec(vt[8]);

      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) chk_int("in_flight_left", i, q[i].size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
